// File: rtl/life_step_ctrl.sv
// Generation sequencer for an 8x8 Game-of-Life board: one cell evaluated per clock,
// next generation committed atomically, single-step or free-running at a fixed period.
module life_step_ctrl #(
  parameter int STEP_PERIOD = 12000000,
  parameter int WRAP        = 1,
  parameter int GEN_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      init_board,
  input  logic             load,
  input  logic             run,
  input  logic             step_req,
  output logic [63:0]      board,
  output logic             busy,
  output logic             step_done,
  output logic             stable,
  output logic [GEN_W-1:0] gen_count
);

  localparam int CNT_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEP_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, WAIT, COMPUTE, COMMIT} state_t;

  state_t           state, state_nx;
  logic [5:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      nxt;
  logic [3:0]       n;
  logic             cell_nx;

  // Neighbour count for cell idx, read from the committed board only.
  always_comb begin
    int rr, cc;
    n = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = int'(idx[5:3]) + dr;
        cc = int'(idx[2:0]) + dc;
        if (!(dr == 0 && dc == 0) &&
            ((WRAP != 0) || (rr >= 0 && rr < 8 && cc >= 0 && cc < 8)))
          n = n + {3'b0, board[{rr[2:0], cc[2:0]}]};
      end
    end
  end

  assign cell_nx = (n == 4'd3) | (board[idx] & (n == 4'd2));
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (run) state_nx = WAIT;
               else if (step_req) state_nx = COMPUTE;
      WAIT:    if (!run) state_nx = IDLE;
               else if (cnt == '0) state_nx = COMPUTE;
      COMPUTE: if (idx == 6'd63) state_nx = COMMIT;
      COMMIT:  state_nx = run ? WAIT : IDLE;
      default: state_nx = IDLE;
    endcase
    if (load) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board     <= '0;
      nxt       <= '0;
      idx       <= '0;
      cnt       <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
      step_done <= 1'b0;
    end else begin
      step_done <= 1'b0;
      if (load) begin
        board     <= init_board;
        gen_count <= '0;
        stable    <= 1'b0;
        idx       <= '0;
      end else begin
        case (state)
          IDLE: begin
            idx <= '0;
            if (run) cnt <= CNT_LOAD;
          end
          WAIT: begin
            idx <= '0;
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
          COMPUTE: begin
            nxt[idx] <= cell_nx;
            idx      <= idx + 6'd1;
          end
          COMMIT: begin
            board     <= nxt;
            gen_count <= gen_count + GEN_W'(1);
            stable    <= (nxt == board);
            step_done <= 1'b1;
            if (run) cnt <= CNT_LOAD;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_life_step_ctrl.sv
// Directed bench for life_step_ctrl: a wrapping and a non-wrapping instance share stimulus.
module tb_life_step_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] init_board = '0;
  logic        load = 1'b0, run = 1'b0, step_req = 1'b0;

  logic [63:0] board_w, board_n;
  logic        busy_w, busy_n, done_w, done_n, stable_w, stable_n;
  logic [15:0] gen_w, gen_n;

  int passed = 0;
  int total  = 0;

  localparam logic [63:0] HORIZ = 64'h000000001C000000;
  localparam logic [63:0] VERT  = 64'h0000000808080000;
  localparam logic [63:0] BLOCK = 64'h0000000000000303;

  always #5 clk = ~clk;

  life_step_ctrl #(.STEP_PERIOD(4), .WRAP(1), .GEN_W(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .init_board(init_board), .load(load), .run(run),
    .step_req(step_req), .board(board_w), .busy(busy_w), .step_done(done_w),
    .stable(stable_w), .gen_count(gen_w));

  life_step_ctrl #(.STEP_PERIOD(4), .WRAP(0), .GEN_W(16)) dut_n (
    .clk(clk), .rst_n(rst_n), .init_board(init_board), .load(load), .run(run),
    .step_req(step_req), .board(board_n), .busy(busy_n), .step_done(done_n),
    .stable(stable_n), .gen_count(gen_n));

  typedef struct {
    logic [63:0] init;
    logic [63:0] exp_w;
    logic [63:0] exp_n;
    logic        st_w;
    logic        st_n;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic do_load(input logic [63:0] b);
    @(negedge clk);
    init_board = b;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!done_w && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " step_done seen"}, 64'(done_w), 64'd1);
  endtask

  task automatic count_pulses(input string nm, input int cycles);
    int p = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done_w) p++;
    end
    chk({nm, " no step_done"}, 64'(p), 64'd0);
  endtask

  initial begin
    vecs[0] = '{HORIZ, VERT, VERT, 1'b0, 1'b0};
    vecs[1] = '{VERT, HORIZ, HORIZ, 1'b0, 1'b0};
    vecs[2] = '{64'h83, 64'h0100000000000101, 64'h0, 1'b0, 1'b0};
    vecs[3] = '{BLOCK, BLOCK, BLOCK, 1'b1, 1'b1};
    vecs[4] = '{64'h0, 64'h0, 64'h0, 1'b1, 1'b1};
    vecs[5] = '{64'h8100000000000081, 64'h8100000000000081, 64'h0, 1'b1, 1'b0};

    // reset state
    #12;
    chk("rst board", board_w, 64'h0);
    chk("rst gen", 64'(gen_w), 64'h0);
    chk("rst busy", 64'(busy_w), 64'h0);
    chk("rst done", 64'(done_w), 64'h0);
    chk("rst stable", 64'(stable_w), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // table: load, single step, compare both edge modes
    for (int v = 0; v < 6; v++) begin
      do_load(vecs[v].init);
      chk($sformatf("v%0d load board", v), board_w, vecs[v].init);
      chk($sformatf("v%0d load gen", v), 64'(gen_w), 64'h0);
      chk($sformatf("v%0d load stable", v), 64'(stable_w), 64'h0);
      pulse_step();
      wait_done($sformatf("v%0d", v));
      chk($sformatf("v%0d board wrap", v), board_w, vecs[v].exp_w);
      chk($sformatf("v%0d board nowrap", v), board_n, vecs[v].exp_n);
      chk($sformatf("v%0d stable wrap", v), 64'(stable_w), 64'(vecs[v].st_w));
      chk($sformatf("v%0d stable nowrap", v), 64'(stable_n), 64'(vecs[v].st_n));
      chk($sformatf("v%0d gen", v), 64'(gen_w), 64'h1);
    end

    // exact latency: step_done and new board appear after the 65th edge
    do_load(HORIZ);
    pulse_step();
    repeat (64) @(negedge clk);
    chk("lat done early", 64'(done_w), 64'h0);
    chk("lat board held", board_w, HORIZ);
    chk("lat busy", 64'(busy_w), 64'h1);
    @(negedge clk);
    chk("lat done", 64'(done_w), 64'h1);
    chk("lat board", board_w, VERT);
    chk("lat gen", 64'(gen_w), 64'h1);
    @(negedge clk);
    chk("lat done pulse", 64'(done_w), 64'h0);
    chk("lat idle", 64'(busy_w), 64'h0);
    pulse_step();
    wait_done("blink2");
    chk("blink2 board", board_w, HORIZ);
    chk("blink2 gen", 64'(gen_w), 64'h2);

    // still life then load clears stable
    do_load(BLOCK);
    pulse_step();
    wait_done("still");
    chk("still stable", 64'(stable_w), 64'h1);
    do_load(BLOCK);
    chk("still reload stable", 64'(stable_w), 64'h0);

    // run mode: period STEP_PERIOD+65 = 69
    do_load(HORIZ);
    @(negedge clk);
    run = 1'b1;
    wait_done("run1");
    chk("run1 board", board_w, VERT);
    chk("run1 gen", 64'(gen_w), 64'h1);
    begin
      int k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!done_w && k < 300);
      chk("run period", 64'(k), 64'd69);
    end
    chk("run2 board", board_w, HORIZ);
    chk("run2 gen", 64'(gen_w), 64'h2);
    run = 1'b0;
    @(negedge clk);
    chk("run stop idle", 64'(busy_w), 64'h0);
    count_pulses("run stop", 150);
    chk("run stop gen", 64'(gen_w), 64'h2);

    // abort at idx 30 with load (step_req also high, load wins)
    do_load(HORIZ);
    pulse_step();
    repeat (30) @(negedge clk);
    init_board = BLOCK;
    load = 1'b1;
    step_req = 1'b1;
    @(negedge clk);
    load = 1'b0;
    step_req = 1'b0;
    chk("abort board", board_w, BLOCK);
    chk("abort gen", 64'(gen_w), 64'h0);
    chk("abort busy", 64'(busy_w), 64'h0);
    chk("abort done", 64'(done_w), 64'h0);
    count_pulses("abort", 100);

    // step_req during COMPUTE is ignored
    do_load(HORIZ);
    pulse_step();
    repeat (10) @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    wait_done("ignore");
    chk("ignore gen", 64'(gen_w), 64'h1);
    count_pulses("ignore", 100);
    chk("ignore gen after", 64'(gen_w), 64'h1);

    // async reset mid-COMPUTE
    do_load(HORIZ);
    pulse_step();
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst board", board_w, 64'h0);
    chk("arst busy", 64'(busy_w), 64'h0);
    chk("arst gen", 64'(gen_w), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_step();
    wait_done("zero");
    chk("zero board", board_w, 64'h0);
    chk("zero stable", 64'(stable_w), 64'h1);
    chk("zero gen", 64'(gen_w), 64'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
